// File: rtl/imem_program_loader_pkg.sv
// LoaderPkg: loader FSM state type and MIPS word packing helpers.
package LoaderPkg;

  import Opcodes::*;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2,
    LD_ERR  = 2'd3
  } loader_state_t;

  // R-type: shamt is always zero for the core's ALU operations.
  function automatic logic [31:0] pack_rtype(input logic [4:0] rs,
                                             input logic [4:0] rt,
                                             input logic [4:0] rd,
                                             input logic [5:0] funct);
    return {OP_RR, rs, rt, rd, 5'b00000, funct};
  endfunction

  // I-type: loads, stores, branches and immediate arithmetic.
  function automatic logic [31:0] pack_itype(input logic [5:0]  op,
                                             input logic [4:0]  rs,
                                             input logic [4:0]  rt,
                                             input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // J-type: 26-bit word-aligned jump target.
  function automatic logic [31:0] pack_jtype(input logic [25:0] target);
    return {OP_J, target};
  endfunction

endpackage : LoaderPkg

// File: rtl/opcodes.sv
// Opcodes: primary opcode values decoded by the single-cycle core.
// Shared by everything that produces or consumes MIPS instruction words.
package Opcodes;

  localparam logic [5:0] OP_RR    = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

endpackage : Opcodes

// File: rtl/imem_program_loader_instr_encoder.sv
// instr_encoder: purely combinational field-to-word encoder. op_ok_o is low
// for any opcode the core cannot decode, and the word is then forced to zero.
module instr_encoder
  import Opcodes::*, LoaderPkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        op_ok_o
);

  // Select the instruction format from the opcode and pack the fields.
  always_comb begin
    word_o  = 32'h0000_0000;
    op_ok_o = 1'b0;
    case (opcode_i)
      OP_RR: begin
        word_o  = pack_rtype(rs_i, rt_i, rd_i, funct_i);
        op_ok_o = 1'b1;
      end
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ADDIU: begin
        word_o  = pack_itype(opcode_i, rs_i, rt_i, imm_i);
        op_ok_o = 1'b1;
      end
      OP_J: begin
        word_o  = pack_jtype(target_i);
        op_ok_o = 1'b1;
      end
      default: begin
        word_o  = 32'h0000_0000;
        op_ok_o = 1'b0;
      end
    endcase
  end

endmodule : instr_encoder

// File: rtl/imem_program_loader.sv
// imem_program_loader: accepts instruction-field beats over valid/ready,
// encodes them and writes consecutive IMEM words one cycle after acceptance.
// Loading stops at the last beat (DONE) or when IMEM fills up (ERR).
module imem_program_loader
  import LoaderPkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [5:0]        in_opcode_i,
  input  logic [4:0]        in_rs_i,
  input  logic [4:0]        in_rt_i,
  input  logic [4:0]        in_rd_i,
  input  logic [5:0]        in_funct_i,
  input  logic [15:0]       in_imm_i,
  input  logic [25:0]       in_target_i,
  input  logic              in_last_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_full_o,
  output logic              err_badop_o,
  output logic [ADDR_W:0]   word_count_o
);

  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(IMEM_DEPTH - 1);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_full_q, err_full_d;
  logic              err_badop_q, err_badop_d;

  logic [31:0]       word_s;
  logic              op_ok_s;
  logic              beat_fire_s;
  logic              at_last_addr_s;

  instr_encoder u_encoder (
    .opcode_i (in_opcode_i),
    .rs_i     (in_rs_i),
    .rt_i     (in_rt_i),
    .rd_i     (in_rd_i),
    .funct_i  (in_funct_i),
    .imm_i    (in_imm_i),
    .target_i (in_target_i),
    .word_o   (word_s),
    .op_ok_o  (op_ok_s)
  );

  assign beat_fire_s    = in_valid_i && (state_q == LD_LOAD);
  assign at_last_addr_s = (wr_ptr_q == PTR_LAST);

  // Next-state, pointer, error flag and write-port logic.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_full_d  = err_full_q;
    err_badop_d = err_badop_q;
    case (state_q)
      LD_IDLE, LD_DONE, LD_ERR: begin
        if (start_i) begin
          state_d     = LD_LOAD;
          wr_ptr_d    = {ADDR_W{1'b0}};
          count_d     = {(ADDR_W+1){1'b0}};
          err_full_d  = 1'b0;
          err_badop_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      LD_LOAD: begin
        if (beat_fire_s) begin
          if (op_ok_s) begin
            we_d    = 1'b1;
            addr_d  = wr_ptr_q;
            wdata_d = word_s;
            count_d = count_q + CNT_ONE;
            if (at_last_addr_s) begin
              // The pointer is held at the top address so it never wraps.
              wr_ptr_d = wr_ptr_q;
              if (in_last_i) begin
                state_d = LD_DONE;
              end else begin
                state_d    = LD_ERR;
                err_full_d = 1'b1;
              end
            end else begin
              wr_ptr_d = wr_ptr_q + PTR_ONE;
              if (in_last_i) begin
                state_d = LD_DONE;
              end else begin
                state_d = LD_LOAD;
              end
            end
          end else begin
            // Unsupported opcode: beat is consumed but nothing is written.
            err_badop_d = 1'b1;
            if (in_last_i) begin
              state_d = LD_DONE;
            end else begin
              state_d = LD_LOAD;
            end
          end
        end else begin
          state_d = LD_LOAD;
        end
      end
      default: begin
        state_d = LD_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears every output immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LD_IDLE;
      wr_ptr_q    <= {ADDR_W{1'b0}};
      count_q     <= {(ADDR_W+1){1'b0}};
      we_q        <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= 32'h0000_0000;
      err_full_q  <= 1'b0;
      err_badop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_full_q  <= err_full_d;
      err_badop_q <= err_badop_d;
    end
  end

  assign in_ready_o   = (state_q == LD_LOAD);
  assign busy_o       = (state_q == LD_LOAD);
  assign done_o       = (state_q == LD_DONE);
  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign err_full_o   = err_full_q;
  assign err_badop_o  = err_badop_q;
  assign word_count_o = count_q;

endmodule : imem_program_loader
